// File: rtl/bias_relu_fire4_expand1_if.sv
// Valid/ready stream bundle for the fire4 expand1 bias/ReLU stage:
// accumulator words in, requantised activations out.
interface bias_relu_fire4_expand1_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int CH_W  = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/bias_relu_fire4_expand1.sv
// Adds the per-channel fire4 expand1 bias, applies ReLU, rounds/shifts and
// saturates to OUT_W bits through a two-stage pipeline with a shared stall.
module bias_relu_fire4_expand1 #(
    parameter int CHANNELS = 128,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 8,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACC_W-1:0]      bias_mem_i [0:CHANNELS-1],
    input  logic                  clear_i,
    bias_relu_fire4_expand1_if.slave bus,
    output logic [15:0]           sat_cnt_o
);
    localparam logic signed [ACC_W+1:0] RND     = {{(ACC_W+1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W+1:0] OUT_MAX = (ACC_W+2)'(2**(OUT_W-1) - 1);
    localparam logic [CH_W-1:0]         CH_LAST = CH_W'(CHANNELS - 1);

    logic                    en;
    logic                    hs;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [ACC_W-1:0]        bias_w;
    logic                    s1_valid_q;
    logic signed [ACC_W:0]   s1_sum_q, s1_sum_d;
    logic [CH_W-1:0]         s1_ch_q;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic [CH_W-1:0]         out_ch_q;
    logic                    out_last_q;
    logic [15:0]             sat_q;
    logic signed [ACC_W+1:0] rnd;
    logic signed [ACC_W+1:0] shr;
    logic                    sat_flag;

    assign bias_w = bias_mem_i[ch_q];

    always_comb begin
        en = !out_valid_q || bus.out_ready;
        hs = bus.in_valid && en;

        ch_d = ch_q;
        if (clear_i) begin
            ch_d = '0;
        end else if (hs) begin
            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        end

        s1_sum_d = $signed({bus.in_data[ACC_W-1], bus.in_data})
                 + $signed({bias_w[ACC_W-1], bias_w});

        // ReLU decision is taken on the unrounded sum.
        rnd        = $signed({s1_sum_q[ACC_W], s1_sum_q}) + RND;
        shr        = rnd >>> SHIFT;
        sat_flag   = 1'b0;
        out_data_d = shr[OUT_W-1:0];
        if (s1_sum_q[ACC_W]) begin
            out_data_d = '0;
        end else if (shr > OUT_MAX) begin
            out_data_d = OUT_MAX[OUT_W-1:0];
            sat_flag   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_ch_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= '0;
        end else begin
            ch_q <= ch_d;
            if (en) begin
                s1_valid_q  <= bus.in_valid;
                s1_sum_q    <= s1_sum_d;
                s1_ch_q     <= ch_q;
                out_valid_q <= s1_valid_q;
                out_data_q  <= out_data_d;
                out_ch_q    <= s1_ch_q;
                out_last_q  <= (s1_ch_q == CH_LAST);
                if (s1_valid_q && sat_flag && (sat_q != 16'hFFFF)) begin
                    sat_q <= sat_q + 16'd1;
                end
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_last  = out_last_q;
    assign sat_cnt_o     = sat_q;
endmodule

// File: doc/bias_relu_fire4_expand1.md
# bias_relu_fire4_expand1

Read-side consumer of the fire4 expand1 bias table. It takes the 32-bit accumulator stream from the expand1 convolution engine, one word per output channel in channel order 0..CHANNELS-1. For each word it adds the bias for the current channel, applies ReLU, rounds and right-shifts, and saturates to OUT_W bits. The result goes to the fire4 concat/writeback stage over a valid/ready stream, through a 2-stage stallable pipeline.

## Interface
- CHANNELS, 128, output channels per pixel; channel counter range 0..CHANNELS-1
- ACC_W, 32, accumulator and bias width, two's complement
- OUT_W, 16, output activation width, signed format, value always >= 0
- SHIFT, 8, requantization right shift, must be >= 1
- CH_W, $clog2(CHANNELS), channel index width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- bias_mem  in  ACC_W x [0:CHANNELS-1]  bias table, static after configuration
- clear  in  1  synchronous pulse; returns channel counter to 0, does not flush pipeline
- in_valid  in  1  accumulator word valid
- in_ready  out  1  stage accepts input
- in_data  in  ACC_W  signed accumulator value for channel ch_cnt
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_W  activation
- out_ch  out  CH_W  channel index of out_data
- out_last  out  1  high when out_ch == CHANNELS-1
- sat_cnt  out  16  count of saturated outputs, sticks at 0xFFFF

## Operation
- The channel counter ch_cnt increments on each input handshake (in_valid && in_ready).
  - Wraps from CHANNELS-1 to 0.
  - clear forces it to 0. If clear coincides with a handshake, the accepted word uses the pre-clear index and the counter ends at 0.
- Stage 1 register:
  - s1_sum = sext(in_data) + sext(bias_mem[ch_cnt]), width ACC_W+1.
  - s1_ch = ch_cnt, s1_valid.
- Stage 2 register (the output register):
  - r = s1_sum + 2^(SHIFT-1), width ACC_W+2, arithmetic shift right by SHIFT.
  - If s1_sum < 0 (ReLU), out_data = 0. The ReLU test uses s1_sum, before rounding.
  - Else if r > 2^(OUT_W-1)-1, out_data = 2^(OUT_W-1)-1 and the saturation is flagged.
  - Else out_data = r[OUT_W-1:0].
  - out_ch = s1_ch. out_last = (s1_ch == CHANNELS-1).
- sat_cnt increments by 1 when a flagged word is loaded into stage 2. It saturates at 0xFFFF and never wraps.
- No arithmetic overflow is allowed anywhere: all intermediate widths are extended as listed above.

## Timing
- Global enable: en = !out_valid || out_ready. Both stages load only when en is high. in_ready = en.
- Bubbles are not collapsed: an invalid stage 1 still advances.
- Latency: 2 cycles from input handshake to out_valid when out_ready stays high. Throughput is 1 word per cycle.
- Stall: while out_valid && !out_ready, every register holds. out_data, out_ch and out_last stay stable until the handshake.
- Reset (rst=1 at a clock edge) sets ch_cnt=0, s1_valid=0, out_valid=0, out_data=0, out_ch=0, out_last=0, sat_cnt=0. Reset wins over clear and over any handshake in the same cycle.
- During rst, in_ready is driven 1, because out_valid=0. Inputs presented while rst=1 are discarded and do not advance ch_cnt.
- Reset in mid-frame drops all in-flight words; the next accepted word is channel 0.
- bias_mem is sampled combinationally in the same cycle as the handshake. It must not change while frames are in flight.

## Test plan
- ch0 bias -93, in_data 4096, out_ready=1 -> 2 cycles later out_data=16, out_ch=0, out_last=0, sat_cnt=0.
- ch3 bias 100, in_data 0x7FFFFFFF -> out_data=32767, sat_cnt increments to 1, with no wrap of the 33-bit sum.
- in_data -1000 on a channel with bias 100 -> out_data=0, no saturation count. in_data -50 with bias 30 (sum -20) -> out_data 0.
- Stream 130 words back-to-back -> out_ch runs 0..127 then 0,1. out_last is high exactly once, on channel 127. A clear pulse after word 5 makes the next word channel 0.
- Hold out_ready=0 for 5 cycles with 3 words offered -> in_ready drops after the pipe fills, out_data is stable, and no word is lost or duplicated after release.
- Assert rst for 1 cycle with 2 words in flight -> out_valid=0 and sat_cnt=0 on the next cycle, and the next accepted word reports out_ch=0.
